// File: rtl/usb_utmi_rx.sv
// UTMI receive front-end: SYNC hunt, NRZI decode, bit unstuff,
// LSB-first byte assembly, EOP and line-error detection.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    UTMI_LS_SE0 = 2'b00,
    UTMI_LS_DJ  = 2'b01,
    UTMI_LS_DK  = 2'b10,
    UTMI_LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [1:0] {
    UTMI_OM_NORMAL  = 2'b00,
    UTMI_OM_NONDRV  = 2'b01,
    UTMI_OM_DISABLE = 2'b10,
    UTMI_OM_RSVD    = 2'b11
  } utmi_op_mode_t;

  typedef logic [7:0] bus8_t;

  typedef utmi_line_state_t [7:0] ls_hist_t;

  // Index 0 is the newest symbol: wire order K J K J K J K K
  localparam logic [15:0] USB_SYNC_PATTERN = {
    2'b10, 2'b01, 2'b10, 2'b01,
    2'b10, 2'b01, 2'b10, 2'b10
  };

  localparam logic [2:0] USB_STUFF_BITS_N = 3'd6;

endpackage

module usb_utmi_rx
  import usb_utmi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  utmi_line_state_t line_state,
  input  logic             line_state_en,
  input  utmi_op_mode_t    op_mode,
  input  logic             tx_active,
  output logic             rx_active,
  output logic             rx_valid,
  output bus8_t            rx_data,
  output logic             rx_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_EOP1,
    S_EOP2,
    S_ERR,
    S_WAITJ
  } state_t;

  state_t           state_q, state_d;
  ls_hist_t         hist_q, hist_d, hist_sh;
  utmi_line_state_t prev_q, prev_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       bcnt_q, bcnt_d;
  bus8_t            byte_q, byte_d;
  logic             act_q, act_d;
  logic             vld_q, vld_d;
  bus8_t            data_q, data_d;
  logic             err_q, err_d;

  logic block;
  logic is_j, is_k, is_se0;
  logic dbit, sync_hit, stuff_pos;

  assign block  = tx_active
                | (op_mode == UTMI_OM_DISABLE);
  assign is_j   = (line_state == UTMI_LS_DJ);
  assign is_k   = (line_state == UTMI_LS_DK);
  assign is_se0 = (line_state == UTMI_LS_SE0);
  assign dbit   = (line_state == prev_q);
  assign stuff_pos = (ones_q == USB_STUFF_BITS_N);

  always_comb begin
    hist_sh[0] = line_state;
    for (int i = 1; i < 8; i++) begin
      hist_sh[i] = hist_q[i-1];
    end
  end

  assign sync_hit = (hist_sh == USB_SYNC_PATTERN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        hist_q[i] <= UTMI_LS_DJ;
      end
      prev_q <= UTMI_LS_SE0;
      ones_q <= '0;
      bcnt_q <= '0;
      byte_q <= '0;
      act_q  <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      bcnt_q  <= bcnt_d;
      byte_q  <= byte_d;
      act_q   <= act_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (block) begin
      state_d = S_IDLE;
    end else if (line_state_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (sync_hit) state_d = S_RX;
        end
        S_RX: begin
          if (is_j || is_k) begin
            if (stuff_pos && dbit) state_d = S_ERR;
          end else if (is_se0) begin
            state_d = S_EOP1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_EOP1: begin
          state_d = is_se0 ? S_EOP2 : S_ERR;
        end
        S_EOP2: begin
          if (is_j) state_d = S_IDLE;
          else if (!is_se0) state_d = S_ERR;
        end
        S_ERR: begin
          state_d = S_WAITJ;
        end
        S_WAITJ: begin
          if (is_j) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hist_d = hist_q;
    prev_d = prev_q;
    ones_d = ones_q;
    bcnt_d = bcnt_q;
    byte_d = byte_q;
    act_d  = act_q;
    vld_d  = 1'b0;
    data_d = data_q;
    err_d  = 1'b0;
    if (block) begin
      for (int i = 0; i < 8; i++) begin
        hist_d[i] = UTMI_LS_DJ;
      end
      act_d = 1'b0;
    end else if (line_state_en) begin
      act_d = (state_d == S_RX)
            | (state_d == S_EOP1)
            | (state_d == S_EOP2);
      err_d = (state_d == S_ERR);
      if (state_q == S_IDLE) begin
        hist_d = hist_sh;
        if (sync_hit) begin
          for (int i = 0; i < 8; i++) begin
            hist_d[i] = UTMI_LS_DJ;
          end
          prev_d = UTMI_LS_DK;
          ones_d = 3'd1;
          bcnt_d = '0;
        end
      end else if (state_q == S_RX && (is_j || is_k)) begin
        prev_d = line_state;
        if (stuff_pos) begin
          if (!dbit) ones_d = '0;
        end else begin
          byte_d = {dbit, byte_q[7:1]};
          ones_d = dbit ? ones_q + 3'd1 : '0;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            vld_d  = 1'b1;
            data_d = byte_d;
          end
        end
      end else if (state_q == S_WAITJ && is_j) begin
        for (int i = 0; i < 8; i++) begin
          hist_d[i] = UTMI_LS_DJ;
        end
      end
    end
  end

  assign rx_active = act_q;
  assign rx_valid  = vld_q;
  assign rx_data   = data_q;
  assign rx_error  = err_q;

endmodule
